multi_channel_freq_divider: RTL

- Runtime-programmable clock-enable divider with `NUM_CH` independent channels.
- Each channel has its own divisor and high-time, so the duty cycle is programmable.
- New settings go into shadow registers and take effect only at a period boundary, so period changes are glitch-free.
- Sits beside the fixed `fsel`-decoded divider and replaces it where software-selectable, phase-alignable rates are needed.

---
 rtl/multi_channel_freq_divider.sv | 109 ++++++++++
 1 files changed

// File: rtl/multi_channel_freq_divider.sv
// Programmable clock-enable divider: NUM_CH channels, each with shadowed divisor and high-time.
// Latency: cfg_ack 1 cycle after a write; settings apply at period end, or next edge if off/resync.
// Backpressure: none; every in-range write is accepted and the last write to a channel wins.
module multi_channel_freq_divider #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int CH_AW  = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_wr,
    input  logic [CH_AW-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] fout,
    output logic [NUM_CH-1:0] tick
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0]  d_q   [NUM_CH];
    logic [CNT_W-1:0]  h_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  ds_q  [NUM_CH];
    logic [CNT_W-1:0]  hs_q  [NUM_CH];
    logic [CNT_W-1:0]  d_n   [NUM_CH];
    logic [CNT_W-1:0]  h_n   [NUM_CH];
    logic [CNT_W-1:0]  cnt_n [NUM_CH];
    logic [NUM_CH-1:0] pend_q, fout_q, tick_q;
    logic [NUM_CH-1:0] pend_n, fout_n, tick_n;
    logic [NUM_CH-1:0] sel, run, wrap, apply, frozen;
    logic              ack_q;
    logic              wr_ok;

    assign wr_ok = cfg_wr && (int'(cfg_ch) < NUM_CH);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]    = wr_ok && (int'(cfg_ch) == i);
            run[i]    = d_q[i] >= TWO;
            wrap[i]   = run[i] && en && (cnt_q[i] == d_q[i] - ONE);
            apply[i]  = pend_q[i] && (resync || !run[i] || wrap[i]);
            frozen[i] = run[i] && !en && !resync;

            d_n[i] = apply[i] ? ds_q[i] : d_q[i];
            h_n[i] = apply[i] ? hs_q[i] : h_q[i];

            if (resync || !run[i] || wrap[i]) begin
                cnt_n[i] = '0;
            end else if (en) begin
                cnt_n[i] = cnt_q[i] + ONE;
            end else begin
                cnt_n[i] = cnt_q[i];
            end

            // A write in the apply cycle re-arms pending with the fresh shadow value.
            pend_n[i] = sel[i] | (pend_q[i] & ~apply[i]);

            // Outputs are derived from next-state so they line up with the cnt they describe.
            if (frozen[i]) begin
                fout_n[i] = fout_q[i];
                tick_n[i] = 1'b0;
            end else begin
                fout_n[i] = (d_n[i] >= TWO) && (cnt_n[i] < h_n[i]);
                tick_n[i] = (d_n[i] >= TWO) && (cnt_n[i] == d_n[i] - ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_q[i]   <= '0;
                h_q[i]   <= '0;
                cnt_q[i] <= '0;
                ds_q[i]  <= '0;
                hs_q[i]  <= '0;
            end
            pend_q <= '0;
            fout_q <= '0;
            tick_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_q[i]   <= d_n[i];
                h_q[i]   <= h_n[i];
                cnt_q[i] <= cnt_n[i];
                if (sel[i]) begin
                    ds_q[i] <= cfg_div;
                    hs_q[i] <= cfg_high;
                end
            end
            pend_q <= pend_n;
            fout_q <= fout_n;
            tick_q <= tick_n;
            ack_q  <= wr_ok;
        end
    end

    assign cfg_ack = ack_q;
    assign pending = pend_q;
    assign fout    = fout_q;
    assign tick    = tick_q;

endmodule
